// File: rtl/divvy_pkg.sv
// Shared definitions for the program-launch controller and the assembler/loader.
// PROG_BASE holds the load address of each program in launch order.
package divvy_pkg;

  localparam int ADDR_W    = 10;
  localparam int NUM_PROGS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } run_state_t;

  localparam logic [ADDR_W-1:0] PROG_BASE [NUM_PROGS] = '{10'd0, 10'd64, 10'd128};

endpackage

// File: rtl/run_cycle_counter.sv
// Run-cycle counter with a registered terminal flag that is high while the
// count sits at MAX_CYCLES-1, i.e. on the last cycle the watchdog allows.
module run_cycle_counter #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             term_d, term_q;

  // Next count and terminal flag; the flag is derived from the next count so it
  // is aligned with the registered value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    term_d = (cnt_d == CNT_W'(MAX_CYCLES - 1));
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      term_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

  assign count = cnt_q;
  assign term  = term_q;

endmodule

// File: rtl/run_ctrl.sv
// Responder for the START/DONE launch handshake: loads the PC with the next
// program's base, enables execution, and signals DONE on HALT or watchdog.
module run_ctrl #(
  parameter int ADDR_W     = divvy_pkg::ADDR_W,
  parameter int NUM_PROGS  = divvy_pkg::NUM_PROGS,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4096
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              HALT,
  output logic              PC_LOAD,
  output logic [ADDR_W-1:0] PC_INIT,
  output logic              RUN_EN,
  output logic              DONE,
  output logic [1:0]        PROG_IDX,
  output logic [CNT_W-1:0]  CYCLE_CNT,
  output logic              TIMEOUT
);

  import divvy_pkg::*;

  run_state_t        state_d, state_q;
  logic              pc_load_d, pc_load_q;
  logic              run_en_d, run_en_q;
  logic              done_d, done_q;
  logic              timeout_d, timeout_q;
  logic [1:0]        prog_idx_d, prog_idx_q;
  logic [ADDR_W-1:0] pc_init_d, pc_init_q;
  logic              cnt_clr, cnt_en, wd_term;
  logic [CNT_W-1:0]  cnt_val;

  run_cycle_counter #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_val),
    .term  (wd_term)
  );

  // Next state, launch bookkeeping and next-state-decoded (Moore) outputs.
  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q;
    prog_idx_d = prog_idx_q;
    pc_init_d  = pc_init_q;

    case (state_q)
      IDLE: begin
        if (START) state_d = LOAD;
        else       state_d = IDLE;
      end
      LOAD: begin
        if (START) state_d = LOAD;
        else       state_d = RUN;
      end
      RUN: begin
        // HALT has priority over the watchdog in the same cycle.
        if (HALT) begin
          state_d   = FIN;
          timeout_d = 1'b0;
        end else if (wd_term) begin
          state_d   = FIN;
          timeout_d = 1'b1;
        end else begin
          state_d   = RUN;
        end
      end
      FIN: begin
        if (START) state_d = LOAD;
        else       state_d = FIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == LOAD) begin
      timeout_d = 1'b0;
      pc_init_d = ADDR_W'(PROG_BASE[prog_idx_q]);
    end else begin
      pc_init_d = pc_init_q;
    end

    if ((state_q == RUN) && (state_d == FIN)) begin
      if (prog_idx_q == 2'(NUM_PROGS - 1)) prog_idx_d = 2'd0;
      else                                 prog_idx_d = prog_idx_q + 2'd1;
    end else begin
      prog_idx_d = prog_idx_q;
    end

    pc_load_d = (state_d == LOAD);
    run_en_d  = (state_d == RUN);
    done_d    = (state_d == FIN);
    cnt_clr   = (state_d == LOAD);
    cnt_en    = (state_q == RUN);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      pc_load_q  <= 1'b0;
      run_en_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      prog_idx_q <= 2'd0;
      pc_init_q  <= ADDR_W'(PROG_BASE[0]);
    end else begin
      state_q    <= state_d;
      pc_load_q  <= pc_load_d;
      run_en_q   <= run_en_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      prog_idx_q <= prog_idx_d;
      pc_init_q  <= pc_init_d;
    end
  end

  assign PC_LOAD   = pc_load_q;
  assign PC_INIT   = pc_init_q;
  assign RUN_EN    = run_en_q;
  assign DONE      = done_q;
  assign PROG_IDX  = prog_idx_q;
  assign CYCLE_CNT = cnt_val;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: a launch-level reference model predicts the
// outputs after every clock edge and a monitor compares them at the falling edge.
module tb_run_ctrl;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;
  localparam int MAXC   = 20;
  localparam int NPROG  = 3;

  logic              CLK = 1'b0;
  logic              RESET, START, HALT;
  logic              PC_LOAD, RUN_EN, DONE, TIMEOUT;
  logic [ADDR_W-1:0] PC_INIT;
  logic [1:0]        PROG_IDX;
  logic [CNT_W-1:0]  CYCLE_CNT;

  run_ctrl #(
    .ADDR_W(ADDR_W), .NUM_PROGS(NPROG), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .HALT(HALT),
    .PC_LOAD(PC_LOAD), .PC_INIT(PC_INIT), .RUN_EN(RUN_EN), .DONE(DONE),
    .PROG_IDX(PROG_IDX), .CYCLE_CNT(CYCLE_CNT), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        pc_load;
    logic [31:0] pc_init;
    logic        run_en;
    logic        done;
    logic [31:0] prog_idx;
    logic [31:0] cnt;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: where we are in the launch sequence, counted in plain integers.
  bit m_loading, m_running, m_finished, m_timeout;
  int m_prog, m_len, m_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_loading = 0; m_running = 0; m_finished = 0; m_timeout = 0;
    m_prog = 0; m_len = 0; m_base = 0;
  endfunction

  function automatic void model_step(input bit s, input bit h);
    if (m_running) begin
      m_len = m_len + 1;
      if (h || m_len == MAXC) begin
        m_running  = 0;
        m_finished = 1;
        m_timeout  = !h;
        m_prog     = (m_prog + 1) % NPROG;
      end
    end else if (m_loading) begin
      if (!s) begin
        m_loading = 0;
        m_running = 1;
      end
    end else if (s) begin
      m_loading  = 1;
      m_finished = 0;
      m_timeout  = 0;
      m_len      = 0;
      m_base     = 64 * m_prog;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.pc_load  = m_loading;
    e.pc_init  = m_base;
    e.run_en   = m_running;
    e.done     = m_finished;
    e.prog_idx = m_prog;
    e.cnt      = m_len;
    e.timeout  = m_timeout;
    return e;
  endfunction

  // One clock: drive inputs, let the edge happen, record what should now be visible.
  task automatic cycle(input logic s, input logic h);
    START = s;
    HALT  = h;
    @(posedge CLK);
    #1;
    model_step(s, h);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // mode 0: clean; mode 1: random START/HALT noise where it must be ignored;
  // mode 2: START pulse on RUN cycles 3-4.
  task automatic launch(input int slen, input int halt_at, input int mode);
    for (int i = 0; i < slen; i++)
      cycle(1'b1, (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 1; i <= halt_at; i++) begin
      logic s;
      s = 1'b0;
      if (mode == 2 && (i == 3 || i == 4)) s = 1'b1;
      if (mode == 1 && i < halt_at && i < MAXC) s = 1'($urandom_range(0, 1));
      cycle(s, 1'(i == halt_at));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_load"},  32'(PC_LOAD),   32'd0);
    chk({tag, "_pc_init"},  32'(PC_INIT),   32'd0);
    chk({tag, "_run_en"},   32'(RUN_EN),    32'd0);
    chk({tag, "_done"},     32'(DONE),      32'd0);
    chk({tag, "_prog_idx"}, 32'(PROG_IDX),  32'd0);
    chk({tag, "_cycle_cnt"},32'(CYCLE_CNT), 32'd0);
    chk({tag, "_timeout"},  32'(TIMEOUT),   32'd0);
  endtask

  // Monitor: every falling edge with a pending expectation is compared in full.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_load",   32'(PC_LOAD),   32'(e.pc_load));
        chk("pc_init",   32'(PC_INIT),   e.pc_init);
        chk("run_en",    32'(RUN_EN),    32'(e.run_en));
        chk("done",      32'(DONE),      32'(e.done));
        chk("prog_idx",  32'(PROG_IDX),  e.prog_idx);
        chk("cycle_cnt", 32'(CYCLE_CNT), e.cnt);
        chk("timeout",   32'(TIMEOUT),   32'(e.timeout));
      end
    end
  end

  // Stimulus.
  initial begin
    RESET = 1'b1;
    START = 1'b0;
    HALT  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RESET = 1'b0;

    // First launch, HALT on RUN cycle 10.
    launch(2, 10, 0);
    idle(2);
    // Rotation through all programs and back to the first.
    for (int k = 0; k < 4; k++) begin
      launch(2, 5, 0);
      idle(1);
    end
    // Watchdog expiry, then HALT coinciding with the watchdog cycle.
    launch(2, MAXC + 3, 0);
    idle(2);
    launch(2, MAXC, 0);
    idle(2);
    // START during RUN ignored; START in FIN relaunches.
    launch(2, 8, 2);
    idle(3);

    // Asynchronous reset between edges in the middle of a run.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0);
    #5;
    RESET = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    #1;
    RESET = 1'b0;
    launch(3, 4, 0);
    idle(1);

    // Long START: stays in LOAD until START falls.
    launch(50, 7, 0);
    idle(2);

    // Randomised launches with noise on inputs that must be ignored.
    for (int r = 0; r < 14; r++) begin
      launch($urandom_range(1, 4), $urandom_range(1, MAXC + 4), 1);
      idle($urandom_range(0, 3));
    end

    START = 1'b0;
    HALT  = 1'b0;
    @(negedge CLK);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Responder side of the START/DONE program-launch handshake driven by the test harness into Top.
- Sits inside Top between the START/DONE pins and the fetch unit.
- On each START pulse it loads the PC with the base address of the next program in sequence (0, 1, 2, wrapping), then enables execution.
- It raises DONE when the decoder reports HALT or when a watchdog expires, and reports the run's cycle count.

Parameters:
ADDR_W, 10, instruction address width (PC_INIT width)
NUM_PROGS, 3, number of programs launched in rotation
CNT_W, 16, cycle counter width
MAX_CYCLES, 4096, watchdog limit in RUN cycles (must be at most 2**CNT_W - 1)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  launch request from harness, level; a pulse is several cycles wide
HALT  input  1  from instruction decoder; high for the cycle a halt instruction executes
PC_LOAD  output  1  PC loads PC_INIT this cycle
PC_INIT  output  ADDR_W  base address of the current program
RUN_EN  output  1  fetch/execute enable
DONE  output  1  program finished; held until next START
PROG_IDX  output  2  index of the current/next program, 0..NUM_PROGS-1
CYCLE_CNT  output  CNT_W  RUN cycles consumed by the current/last run
TIMEOUT  output  1  last run ended by watchdog, not HALT

Behaviour:
- All outputs are registered (Moore). There is no combinational path from input to output.
- Reset (async assert, any state): state=IDLE, PC_LOAD=0, RUN_EN=0, DONE=0, PROG_IDX=0, CYCLE_CNT=0, TIMEOUT=0, PC_INIT=PROG_BASE[0].
- States: IDLE, LOAD, RUN, FIN.
- IDLE: START sampled 1 -> LOAD.
- LOAD:
  - PC_LOAD=1 and PC_INIT=PROG_BASE[PROG_IDX].
  - CYCLE_CNT cleared to 0, TIMEOUT cleared, DONE=0.
  - Stays in LOAD while START=1. START sampled 0 -> RUN.
  - START is therefore level-tracked: execution begins only after START falls.
- RUN:
  - RUN_EN=1, PC_LOAD=0.
  - CYCLE_CNT increments by 1 on every RUN cycle.
  - HALT sampled 1 -> FIN with TIMEOUT=0.
  - HALT=0 and CYCLE_CNT==MAX_CYCLES-1 -> FIN with TIMEOUT=1.
  - HALT and watchdog in the same cycle: HALT wins, TIMEOUT=0.
  - START=1 during RUN is ignored (no restart, no effect).
- FIN:
  - DONE=1, RUN_EN=0. CYCLE_CNT and TIMEOUT hold.
  - On the transition into FIN, PROG_IDX <= (PROG_IDX==NUM_PROGS-1) ? 0 : PROG_IDX+1.
  - Stays in FIN while START=0. START sampled 1 -> LOAD, and DONE falls on that same edge.
- Latency:
  - START=1 sampled at edge k: PC_LOAD=1 after edge k.
  - START=0 sampled at edge m: PC_LOAD=0 and RUN_EN=1 after edge m.
  - HALT sampled at edge n: DONE=1 and RUN_EN=0 after edge n. CYCLE_CNT then equals the number of RUN cycles, including the HALT cycle.
- HALT outside RUN is ignored.
- Reset mid-run returns to IDLE with PROG_IDX=0. No partial-done indication is given.
- CYCLE_CNT never wraps: the watchdog guarantees exit before overflow.

Decomposition:
- Shared package divvy_pkg:
  - run_state_t enum {IDLE, LOAD, RUN, FIN}
  - ADDR_W constant
  - PROG_BASE[NUM_PROGS] constant array, default {10'd0, 10'd64, 10'd128}, shared with the assembler/loader
- One sub-module, run_cycle_counter. Inputs: clr, en. Outputs: CNT_W count and a registered terminal flag at MAX_CYCLES-1. Used for CYCLE_CNT and the watchdog.

Test Plan:
- Reset then START high 2 cycles -> PC_LOAD=1 for exactly 2 cycles with PC_INIT=0, then RUN_EN=1. HALT after 10 RUN cycles -> DONE=1, CYCLE_CNT=10, TIMEOUT=0, PROG_IDX=1.
- Three back-to-back launches, each START 2 cycles, each HALT after 5 cycles -> PC_INIT=0, 64, 128 in turn; after the third DONE, PROG_IDX=0. A fourth launch gives PC_INIT=0.
- No HALT, MAX_CYCLES=20 -> DONE rises after 20 RUN cycles with TIMEOUT=1 and CYCLE_CNT=20. HALT on cycle 20 -> TIMEOUT=0.
- START pulsed high during RUN, HALT at 8 -> no PC_LOAD, DONE after 8 cycles. Then START in FIN -> DONE falls on the first sampled START edge and PC_LOAD rises.
- RESET asserted asynchronously mid-RUN (between edges) -> all outputs are 0 immediately with PROG_IDX=0. The next START loads PC_INIT=0.
- START held high 50 cycles -> remains in LOAD with CYCLE_CNT=0 and RUN_EN=0 throughout. RUN begins on the cycle after START falls.
